bb_season_tracker: RTL and testbench

Downstream consumer of the per-game baseball scorer. Each time the scorer pulses its game-end output, this block takes the final scores and result and accumulates season statistics for teams A and B: wins, ties, total runs and win streaks. On request it streams a fixed five-beat report serially on a 16-bit bus.

---
 rtl/bb_season_tracker.sv | 176 +++++++++++++++++
 tb/tb_bb_season_tracker.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bb_season_tracker.sv
// Season statistics accumulator fed by the per-game scorer; streams a
// five-beat snapshot report on request.
module bb_season_tracker #(
  parameter int RUN_W = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [7:0]  score_A,
  input  logic [7:0]  score_B,
  input  logic [1:0]  result,
  input  logic        query,
  input  logic        season_clr,
  output logic        out_valid,
  output logic [15:0] out_data,
  output logic        err
);

  typedef enum logic {IDLE, REPORT} state_t;

  typedef struct packed {
    logic [7:0]       win_a;
    logic [7:0]       win_b;
    logic [7:0]       tie;
    logic [7:0]       games;
    logic [RUN_W-1:0] run_a;
    logic [RUN_W-1:0] run_b;
    logic [1:0]       strk_team;
    logic [7:0]       strk_len;
    logic [7:0]       best_len;
  } stats_t;

  localparam logic [1:0] RES_A   = 2'b00;
  localparam logic [1:0] RES_B   = 2'b01;
  localparam logic [1:0] RES_ILL = 2'b11;
  localparam logic [1:0] TEAM_NONE = 2'b00;
  localparam logic [1:0] TEAM_A    = 2'b01;
  localparam logic [1:0] TEAM_B    = 2'b10;

  state_t      state_q, state_d;
  logic [2:0]  beat_q, beat_d;
  stats_t      stats_q, stats_d;
  stats_t      snap_q, snap_d;
  logic        err_q, err_d;
  logic        out_valid_q, out_valid_d;
  logic [15:0] out_data_q, out_data_d;
  logic        legal;
  logic        accept;
  logic [15:0] snap_run_a16, snap_run_b16;

  function automatic logic [7:0] sat_inc8(input logic [7:0] x);
    return (x == 8'hFF) ? x : x + 8'd1;
  endfunction

  // RUN_W is assumed to be at least 8 so a score always fits the accumulator.
  function automatic logic [RUN_W-1:0] sat_add(input logic [RUN_W-1:0] acc,
                                               input logic [7:0] sc);
    logic [RUN_W:0] sum;
    sum = {1'b0, acc} + {{(RUN_W+1-8){1'b0}}, sc};
    return sum[RUN_W] ? {RUN_W{1'b1}} : sum[RUN_W-1:0];
  endfunction

  if (RUN_W >= 16) begin : g_trunc
    assign snap_run_a16 = snap_q.run_a[15:0];
    assign snap_run_b16 = snap_q.run_b[15:0];
  end else begin : g_ext
    assign snap_run_a16 = {{(16-RUN_W){1'b0}}, snap_q.run_a};
    assign snap_run_b16 = {{(16-RUN_W){1'b0}}, snap_q.run_b};
  end

  // Live statistics update; clear overrides any game in the same cycle.
  always_comb begin
    stats_d = stats_q;
    err_d   = err_q;
    legal   = in_valid && (result != RES_ILL);
    if (in_valid && (result == RES_ILL)) err_d = 1'b1;
    if (legal) begin
      stats_d.games = sat_inc8(stats_q.games);
      stats_d.run_a = sat_add(stats_q.run_a, score_A);
      stats_d.run_b = sat_add(stats_q.run_b, score_B);
      case (result)
        RES_A: begin
          stats_d.win_a = sat_inc8(stats_q.win_a);
          if (stats_q.strk_team == TEAM_A) begin
            stats_d.strk_len = sat_inc8(stats_q.strk_len);
          end else begin
            stats_d.strk_team = TEAM_A;
            stats_d.strk_len  = 8'd1;
          end
        end
        RES_B: begin
          stats_d.win_b = sat_inc8(stats_q.win_b);
          if (stats_q.strk_team == TEAM_B) begin
            stats_d.strk_len = sat_inc8(stats_q.strk_len);
          end else begin
            stats_d.strk_team = TEAM_B;
            stats_d.strk_len  = 8'd1;
          end
        end
        default: begin
          stats_d.tie       = sat_inc8(stats_q.tie);
          stats_d.strk_team = TEAM_NONE;
          stats_d.strk_len  = 8'd0;
        end
      endcase
      if (stats_d.strk_len > stats_q.best_len) stats_d.best_len = stats_d.strk_len;
    end
    if (season_clr) begin
      stats_d = '0;
      err_d   = 1'b0;
    end
  end

  // A query landing on the last beat restarts the report so out_valid never drops.
  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    snap_d      = snap_q;
    out_valid_d = 1'b0;
    out_data_d  = 16'h0000;
    accept      = query && ((state_q == IDLE) || (beat_q == 3'd4));
    if (state_q == REPORT) begin
      out_valid_d = 1'b1;
      case (beat_q)
        3'd0:    out_data_d = {snap_q.win_a, snap_q.win_b};
        3'd1:    out_data_d = {snap_q.tie, snap_q.games};
        3'd2:    out_data_d = snap_run_a16;
        3'd3:    out_data_d = snap_run_b16;
        default: out_data_d = {6'b0, snap_q.strk_team, snap_q.best_len};
      endcase
      if (beat_q == 3'd4) begin
        state_d = IDLE;
        beat_d  = 3'd0;
      end else begin
        beat_d = beat_q + 3'd1;
      end
    end
    if (accept) begin
      state_d = REPORT;
      beat_d  = 3'd0;
      snap_d  = stats_d;
    end
    if (season_clr) begin
      state_d     = IDLE;
      beat_d      = 3'd0;
      snap_d      = '0;
      out_valid_d = 1'b0;
      out_data_d  = 16'h0000;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      beat_q      <= 3'd0;
      stats_q     <= '0;
      snap_q      <= '0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= 16'h0000;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      stats_q     <= stats_d;
      snap_q      <= snap_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign err       = err_q;

endmodule

// File: tb/tb_bb_season_tracker.sv
// Directed + randomized bench for bb_season_tracker against an integer
// model of the season rules.
module tb_bb_season_tracker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  score_A, score_B;
  logic [1:0]  result;
  logic        query;
  logic        season_clr;
  logic        out_valid;
  logic [15:0] out_data;
  logic        err;

  int n_assert = 0;
  int n_fail   = 0;

  // season model, plain integers
  int m_wa, m_wb, m_tie, m_games, m_ra, m_rb, m_st, m_len, m_best, m_err;
  logic [15:0] exp_b[5];

  localparam int RMAX = 65535;

  bb_season_tracker #(.RUN_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .score_A(score_A),
    .score_B(score_B), .result(result), .query(query), .season_clr(season_clr),
    .out_valid(out_valid), .out_data(out_data), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic int sat(input int v, input int m);
    return (v > m) ? m : v;
  endfunction

  function automatic void model_clear();
    m_wa = 0; m_wb = 0; m_tie = 0; m_games = 0; m_ra = 0; m_rb = 0;
    m_st = 0; m_len = 0; m_best = 0; m_err = 0;
  endfunction

  function automatic void model_game(input int a, input int b, input int r);
    if (r == 3) begin
      m_err = 1;
      return;
    end
    m_games = sat(m_games + 1, 255);
    m_ra = sat(m_ra + a, RMAX);
    m_rb = sat(m_rb + b, RMAX);
    if (r == 2) begin
      m_tie = sat(m_tie + 1, 255);
      m_st = 0; m_len = 0;
    end else begin
      if (r == 0) m_wa = sat(m_wa + 1, 255);
      else        m_wb = sat(m_wb + 1, 255);
      if (m_st == r + 1) m_len = sat(m_len + 1, 255);
      else begin m_st = r + 1; m_len = 1; end
    end
    if (m_len > m_best) m_best = m_len;
  endfunction

  function automatic void take_snapshot();
    exp_b[0] = 16'((m_wa << 8) | m_wb);
    exp_b[1] = 16'((m_tie << 8) | m_games);
    exp_b[2] = 16'(m_ra);
    exp_b[3] = 16'(m_rb);
    exp_b[4] = 16'((m_st << 8) | m_best);
  endfunction

  // Drive one game onto the pins (sampled at the next posedge).
  task automatic set_game(input int a, input int b, input int r);
    in_valid = 1'b1;
    score_A  = 8'(a);
    score_B  = 8'(b);
    result   = 2'(r);
    model_game(a, b, r);
  endtask

  task automatic set_rand_game();
    int r;
    r = ($urandom_range(0, 11) == 0) ? 3 : int'($urandom_range(0, 2));
    set_game(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), r);
  endtask

  task automatic game(input int a, input int b, input int r);
    set_game(a, b, r);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Query (optionally with a game in the same cycle); leaves us just after edge t.
  task automatic start_query(input bit with_game, input int a, input int b, input int r);
    query = 1'b1;
    if (with_game) set_game(a, b, r);
    take_snapshot();
    @(negedge clk);
    query = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic beats(input string name, input bit noise, input bit chain);
    logic [15:0] cur[5];
    cur = exp_b;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      query = 1'b0;
      in_valid = 1'b0;
      check($sformatf("%s_v%0d", name, k), {15'b0, out_valid}, 16'h0001);
      check($sformatf("%s_b%0d", name, k), out_data, cur[k]);
      if (chain && k == 3) begin
        query = 1'b1;
        take_snapshot();
      end else if (noise && k < 4 && $urandom_range(0, 1) == 1) begin
        set_rand_game();
      end
    end
    if (!chain) begin
      @(negedge clk);
      in_valid = 1'b0;
      check({name, "_end_v"}, {15'b0, out_valid}, 16'h0000);
      check({name, "_end_d"}, out_data, 16'h0000);
    end
    check({name, "_err"}, {15'b0, err}, 16'(m_err));
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; score_A = '0; score_B = '0; result = '0;
    query = 1'b0; season_clr = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    check("rst_valid", {15'b0, out_valid}, 16'h0000);
    check("rst_data", out_data, 16'h0000);
    check("rst_err", {15'b0, err}, 16'h0000);
    rst_n = 1'b1;
    @(negedge clk);

    // empty season report
    start_query(0, 0, 0, 0);
    check("q_lat_v", {15'b0, out_valid}, 16'h0000);
    beats("empty", 0, 0);

    // A win, B win, tie
    game(5, 3, 0); game(2, 7, 1); game(4, 4, 2);
    start_query(0, 0, 0, 0);
    beats("basic", 0, 0);

    // streak handover
    season_clr = 1'b1; @(negedge clk); season_clr = 1'b0; model_clear();
    game(1, 0, 0); game(2, 0, 0); game(3, 0, 0); game(0, 1, 1);
    start_query(0, 0, 0, 0);
    beats("streak", 0, 0);

    // query with same-cycle game, live updates during report
    season_clr = 1'b1; @(negedge clk); season_clr = 1'b0; model_clear();
    start_query(1, 1, 0, 0);
    beats("qgame", 1, 0);
    start_query(0, 0, 0, 0);
    beats("after", 0, 0);

    // back-to-back reports
    start_query(0, 0, 0, 0);
    beats("chain1", 1, 1);
    beats("chain2", 0, 0);

    // illegal result then clear
    game(9, 9, 3);
    check("ill_err", {15'b0, err}, 16'h0001);
    start_query(0, 0, 0, 0);
    beats("ill", 0, 0);
    season_clr = 1'b1; query = 1'b1; set_game(7, 1, 0);
    @(negedge clk);
    season_clr = 1'b0; query = 1'b0; in_valid = 1'b0; model_clear();
    check("clr_err", {15'b0, err}, 16'h0000);
    check("clr_noq", {15'b0, out_valid}, 16'h0000);
    @(negedge clk);
    check("clr_noq2", {15'b0, out_valid}, 16'h0000);
    start_query(0, 0, 0, 0);
    beats("clr", 0, 0);

    // randomized seasons, consecutive strobes allowed
    for (int round = 0; round < 10; round++) begin
      int n;
      n = int'($urandom_range(3, 40));
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 3) != 0) set_rand_game();
        else in_valid = 1'b0;
        @(negedge clk);
      end
      in_valid = 1'b0;
      start_query($urandom_range(0, 1) == 1, int'($urandom_range(0, 255)),
                  int'($urandom_range(0, 255)), int'($urandom_range(0, 2)));
      beats($sformatf("rnd%0d", round), 1, 0);
    end

    // clear in the middle of a report
    start_query(0, 0, 0, 0);
    @(negedge clk);
    check("mclr_b0", out_data, exp_b[0]);
    season_clr = 1'b1; query = 1'b1;
    @(negedge clk);
    season_clr = 1'b0; query = 1'b0; model_clear();
    check("mclr_v", {15'b0, out_valid}, 16'h0000);
    check("mclr_d", out_data, 16'h0000);
    @(negedge clk);
    check("mclr_v2", {15'b0, out_valid}, 16'h0000);

    // run saturation, 300 consecutive A 255-0 games
    for (int i = 0; i < 300; i++) begin
      set_game(255, 0, 0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    start_query(0, 0, 0, 0);
    beats("sat", 0, 0);

    // asynchronous reset mid-report
    start_query(0, 0, 0, 0);
    @(negedge clk);
    check("arst_pre", {15'b0, out_valid}, 16'h0001);
    #2 rst_n = 1'b0;
    #1;
    check("arst_v", {15'b0, out_valid}, 16'h0000);
    check("arst_d", out_data, 16'h0000);
    check("arst_err", {15'b0, err}, 16'h0000);
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    start_query(0, 0, 0, 0);
    beats("post_rst", 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
